// File: rtl/rv32i_mem_stage_if.sv
// Data-memory bus between the MEM stage and the data memory:
// req/gnt for the address phase, rvalid/rdata for the response.
interface rv32i_mem_stage_if #(
  parameter int XLEN = 32,
  parameter int BE_W = XLEN / 8
);
  logic            dmem_req;
  logic            dmem_we;
  logic [XLEN-1:0] dmem_addr;
  logic [XLEN-1:0] dmem_wdata;
  logic [BE_W-1:0] dmem_be;
  logic            dmem_gnt;
  logic            dmem_rvalid;
  logic [XLEN-1:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr,
    output dmem_wdata, dmem_be,
    input  dmem_gnt, dmem_rvalid, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr,
    input  dmem_wdata, dmem_be,
    output dmem_gnt, dmem_rvalid, dmem_rdata
  );
endinterface

// File: rtl/rv32i_mem_stage.sv
// MEM pipeline stage: data loads/stores over a req/gnt/rvalid
// bus, load extraction, stall generation and the MEM/WB register.
module rv32i_mem_stage #(
  parameter int XLEN  = 32,
  parameter int REG_W = 5,
  parameter int BE_W  = XLEN / 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_in,
  input  logic             flush,
  input  logic [31:0]      pc_in,
  input  logic [31:0]      iw_in,
  input  logic [XLEN-1:0]  alu_in,
  input  logic [XLEN-1:0]  rs2_in,
  input  logic             wb_en_in,
  input  logic [REG_W-1:0] wb_reg_in,
  output logic             stall_out,
  rv32i_mem_stage_if.master dmem,
  output logic             valid_out,
  output logic             wb_en_out,
  output logic [31:0]      pc_out,
  output logic [31:0]      iw_out,
  output logic [XLEN-1:0]  alu_out,
  output logic [REG_W-1:0] wb_reg_out,
  output logic             mem_err,
  output logic             df_mem_enable,
  output logic [REG_W-1:0] df_mem_reg,
  output logic [XLEN-1:0] df_mem_data
);
  localparam int OW = $clog2(BE_W);

  typedef enum logic [1:0] {
    IDLE, WAIT_GNT, WAIT_RSP
  } state_t;

  state_t r_state, w_nxt;

  logic             r_valid, r_wben_o, r_err, r_kill, r_wben;
  logic [31:0]      r_pc_o, r_iw_o, r_pc, r_iw;
  logic [XLEN-1:0]  r_alu;
  logic [REG_W-1:0] r_reg_o, r_reg;
  logic [2:0]       r_f3;
  logic [OW-1:0]    r_off;

  logic [2:0]       w_f3;
  logic [OW-1:0]    w_off;
  logic             w_ld, w_st, w_mem, w_ill, w_mis;
  logic             w_err, w_go;
  logic [XLEN-1:0]  w_sh, w_ldv;
  logic             w_v, w_we, w_e;
  logic [31:0]      w_pc, w_iw;
  logic [XLEN-1:0]  w_alu;
  logic [REG_W-1:0] w_reg;

  assign w_f3  = iw_in[14:12];
  assign w_off = alu_in[OW-1:0];
  assign w_ld  = valid_in && (iw_in[6:0] == 7'b0000011);
  assign w_st  = valid_in && (iw_in[6:0] == 7'b0100011);
  assign w_mem = w_ld || w_st;

  always_comb begin
    w_ill = 1'b0;
    case (w_f3)
      3'b000, 3'b001, 3'b010: w_ill = 1'b0;
      3'b011:                 w_ill = (XLEN != 64);
      3'b100, 3'b101:         w_ill = w_st;
      3'b110:                 w_ill = w_st || (XLEN != 64);
      default:                w_ill = 1'b1;
    endcase
  end

  assign w_mis = (w_off & OW'((4'd1 << w_f3[1:0]) - 4'd1)) != '0;
  assign w_err = w_mem && (w_ill || w_mis);
  assign w_go  = w_mem && !w_ill && !w_mis && !flush;

  assign dmem.dmem_addr = {alu_in[XLEN-1:OW], {OW{1'b0}}};
  assign dmem.dmem_we   = w_st;

  always_comb begin
    dmem.dmem_wdata = rs2_in;
    dmem.dmem_be    = '1;
    case (w_f3[1:0])
      2'b00: begin
        dmem.dmem_wdata = {BE_W{rs2_in[7:0]}};
        dmem.dmem_be    = BE_W'(1) << w_off;
      end
      2'b01: begin
        dmem.dmem_wdata = {(BE_W/2){rs2_in[15:0]}};
        dmem.dmem_be    = BE_W'(3) << w_off;
      end
      2'b10: begin
        dmem.dmem_wdata = {(BE_W/4){rs2_in[31:0]}};
        dmem.dmem_be    = BE_W'(15) << w_off;
      end
      default: begin
        dmem.dmem_wdata = rs2_in;
        dmem.dmem_be    = '1;
      end
    endcase
  end

  always_comb begin
    w_nxt         = r_state;
    dmem.dmem_req = 1'b0;
    stall_out     = 1'b0;
    unique case (r_state)
      WAIT_RSP: begin
        stall_out = !dmem.dmem_rvalid;
        if (dmem.dmem_rvalid) w_nxt = IDLE;
      end
      default: begin
        w_nxt = IDLE;
        if (w_go) begin
          dmem.dmem_req = 1'b1;
          if (!dmem.dmem_gnt) begin
            w_nxt     = WAIT_GNT;
            stall_out = 1'b1;
          end else if (w_ld) begin
            w_nxt     = WAIT_RSP;
            stall_out = 1'b1;
          end
        end
      end
    endcase
  end

  assign w_sh = dmem.dmem_rdata >> {r_off, 3'b000};

  always_comb begin
    w_ldv = w_sh;
    case (r_f3)
      3'b000:  w_ldv = XLEN'($signed(w_sh[7:0]));
      3'b001:  w_ldv = XLEN'($signed(w_sh[15:0]));
      3'b010:  w_ldv = XLEN'($signed(w_sh[31:0]));
      3'b100:  w_ldv = XLEN'(w_sh[7:0]);
      3'b101:  w_ldv = XLEN'(w_sh[15:0]);
      3'b110:  w_ldv = XLEN'(w_sh[31:0]);
      default: w_ldv = w_sh;
    endcase
  end

  // Load in flight uses the copy captured at grant time.
  always_comb begin
    w_pc  = pc_in;
    w_iw  = iw_in;
    w_alu = alu_in;
    w_reg = wb_reg_in;
    w_v   = valid_in && !flush;
    w_we  = wb_en_in && valid_in && !flush;
    w_e   = 1'b0;
    if (r_state == WAIT_RSP) begin
      w_pc  = r_pc;
      w_iw  = r_iw;
      w_alu = w_ldv;
      w_reg = r_reg;
      w_v   = dmem.dmem_rvalid && !r_kill && !flush;
      w_we  = w_v && r_wben;
    end else if (w_mem && !flush) begin
      if (w_err) begin
        w_we = 1'b0;
        w_e  = 1'b1;
      end else if (!(w_st && dmem.dmem_gnt)) begin
        w_v  = 1'b0;
        w_we = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_valid  <= 1'b0;
      r_wben_o <= 1'b0;
      r_pc_o   <= '0;
      r_iw_o   <= '0;
      r_alu    <= '0;
      r_reg_o  <= '0;
      r_err    <= 1'b0;
      r_kill   <= 1'b0;
      r_wben   <= 1'b0;
      r_pc     <= '0;
      r_iw     <= '0;
      r_reg    <= '0;
      r_f3     <= '0;
      r_off    <= '0;
    end else begin
      r_state  <= w_nxt;
      r_valid  <= w_v;
      r_wben_o <= w_we;
      r_pc_o   <= w_pc;
      r_iw_o   <= w_iw;
      r_alu    <= w_alu;
      r_reg_o  <= w_reg;
      r_err    <= w_e;
      if (r_state != WAIT_RSP && w_nxt == WAIT_RSP) begin
        r_kill <= 1'b0;
        r_wben <= wb_en_in;
        r_pc   <= pc_in;
        r_iw   <= iw_in;
        r_reg  <= wb_reg_in;
        r_f3   <= w_f3;
        r_off  <= w_off;
      end else if (r_state == WAIT_RSP && flush) begin
        r_kill <= 1'b1;
      end
    end
  end

  assign valid_out     = r_valid;
  assign wb_en_out     = r_wben_o;
  assign pc_out        = r_pc_o;
  assign iw_out        = r_iw_o;
  assign alu_out       = r_alu;
  assign wb_reg_out    = r_reg_o;
  assign mem_err       = r_err;
  assign df_mem_enable = r_wben_o;
  assign df_mem_reg    = r_reg_o;
  assign df_mem_data   = r_alu;
endmodule
